seq_comparator_ctrl: RTL and testbench

//  Iterative magnitude-compare sequencer. Latches two WIDTH-bit operands on start
//  and walks one internal 2-bit compare slice from the MSB pair down to the LSB pair.

---
 rtl/seq_comparator_ctrl_if.sv | 28 ++
 rtl/seq_comparator_ctrl.sv | 106 ++++++++++
 tb/tb_seq_comparator_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_comparator_ctrl_if.sv
// Requester-side handshake and result bundle for the iterative magnitude comparator.
// The master modport drives start/operands; the slave modport returns status and result.
interface seq_comparator_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int N  = WIDTH / 2;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             l;
    logic [SW-1:0]    slice;

    modport master (
        output start, a, b,
        input  busy, done, g, e, l, slice
    );

    modport slave (
        input  start, a, b,
        output busy, done, g, e, l, slice
    );
endinterface

// File: rtl/seq_comparator_ctrl.sv
// Iterative unsigned magnitude compare, one 2-bit pair per cycle from MSB down, early exit.
// Latency: done 1+j cycles after accept (j = first differing pair below MSB), N if equal.
// Backpressure: start is ignored while busy; no queuing, operands latched only on accept.
module seq_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_comparator_ctrl_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SW-1:0]    slice_q, slice_d;
    logic             done_q, done_d;
    logic             g_q, g_d;
    logic             e_q, e_d;
    logic             l_q, l_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [1:0]       pa;
    logic [1:0]       pb;

    // Shift the active pair down to bit 0 rather than using a variable part-select.
    assign a_sh = a_q >> {slice_q, 1'b0};
    assign b_sh = b_q >> {slice_q, 1'b0};
    assign pa   = a_sh[1:0];
    assign pb   = b_sh[1:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        slice_d = slice_q;
        done_d  = 1'b0;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    slice_d = SW'(N - 1);
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pa > pb) begin
                    g_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (pa < pb) begin
                    l_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (slice_q == '0) begin
                    e_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    slice_d = slice_q - SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            slice_q <= '0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            slice_q <= slice_d;
            done_q  <= done_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.g     = g_q;
    assign bus.e     = e_q;
    assign bus.l     = l_q;
    assign bus.slice = slice_q;
endmodule

// File: tb/tb_seq_comparator_ctrl.sv
// Directed and random checks of seq_comparator_ctrl at WIDTH 2, 8 and 16 against a
// reference compare/latency model, with expectations queued at stimulus time.
module tb_seq_comparator_ctrl;
    logic clk;
    logic rst_n;

    seq_comparator_ctrl_if #(.WIDTH(2))  if2  ();
    seq_comparator_ctrl_if #(.WIDTH(8))  if8  ();
    seq_comparator_ctrl_if #(.WIDTH(16)) if16 ();

    seq_comparator_ctrl #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    seq_comparator_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    seq_comparator_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gel;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [15:0] av, input logic [15:0] bv);
        case (w)
            2: begin if2.start = s; if2.a = av[1:0]; if2.b = bv[1:0]; end
            8: begin if8.start = s; if8.a = av[7:0]; if8.b = bv[7:0]; end
            default: begin if16.start = s; if16.a = av; if16.b = bv; end
        endcase
    endtask

    // {busy, done, g, e, l}
    function automatic logic [4:0] obs(input int w);
        case (w)
            2:       return {if2.busy, if2.done, if2.g, if2.e, if2.l};
            8:       return {if8.busy, if8.done, if8.g, if8.e, if8.l};
            default: return {if16.busy, if16.done, if16.g, if16.e, if16.l};
        endcase
    endfunction

    task automatic run_cmp(input int w, input logic [15:0] av_in, input logic [15:0] bv_in,
                           input string tag);
        int         n;
        int         cyc;
        logic [15:0] mask;
        logic [15:0] av;
        logic [15:0] bv;
        logic [4:0] o;
        exp_t       x;
        exp_t       y;
        n    = w / 2;
        mask = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
        av   = av_in & mask;
        bv   = bv_in & mask;
        x.gel = (av > bv) ? 3'b100 : ((av == bv) ? 3'b010 : 3'b001);
        x.lat = n;
        for (int j = 0; j < n; j++) begin
            int s;
            s = n - 1 - j;
            if (av[2*s +: 2] != bv[2*s +: 2]) begin
                x.lat = j + 1;
                break;
            end
        end
        sb.push_back(x);

        drive(w, 1'b1, av, bv);
        @(posedge clk);
        #1;
        drive(w, 1'b0, av, bv);
        o = obs(w);
        chk({tag, "_accept"}, {27'd0, o}, 32'b10000);

        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            o = obs(w);
            if (!o[3]) chk({tag, "_busy"}, {27'd0, o}, 32'b10000);
        end while (!o[3] && cyc < 40);

        y = sb.pop_front();
        chk({tag, "_result"}, {27'd0, o}, {27'd0, 2'b01, y.gel});
        chk({tag, "_latency"}, cyc, y.lat);

        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {27'd0, obs(w)}, {27'd0, 2'b00, y.gel});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          k;

        rst_n = 1'b0;
        drive(2, 1'b0, 16'h0, 16'h0);
        drive(8, 1'b0, 16'h0, 16'h0);
        drive(16, 1'b0, 16'h0, 16'h0);
        #12;
        chk("reset_out8", {27'd0, obs(8)}, 32'd0);
        chk("reset_out16", {27'd0, obs(16)}, 32'd0);
        chk("reset_slice8", {30'd0, if8.slice}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Equal operands run all four slices.
        run_cmp(8, 16'h00A5, 16'h00A5, "eq_a5");
        // MSB pair decides immediately; slice never leaves N-1.
        run_cmp(8, 16'h0080, 16'h007F, "msb_gt");
        chk("msb_gt_slice", {30'd0, if8.slice}, 32'd3);
        run_cmp(8, 16'h0012, 16'h0013, "lsb_lt");

        // Start held through busy with changing operands, then accepted on the done edge.
        drive(8, 1'b1, 16'h00F0, 16'h00F0);
        @(posedge clk);
        #1;
        drive(8, 1'b1, 16'h0000, 16'h00FF);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("ign_busy", {27'd0, obs(8)}, 32'b10000);
        end
        @(posedge clk);
        #1;
        chk("ign_first_done", {27'd0, obs(8)}, 32'b01010);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 16'h0000, 16'h00FF);
        chk("b2b_accept", {27'd0, obs(8)}, 32'b10000);
        @(posedge clk);
        #1;
        chk("b2b_second_done", {27'd0, obs(8)}, 32'b01001);
        @(posedge clk);
        #1;

        // Reset in the middle of a run aborts without a done pulse.
        drive(8, 1'b1, 16'h00A5, 16'h00A5);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 16'h00A5, 16'h00A5);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out", {27'd0, obs(8)}, 32'd0);
        chk("abort_slice", {30'd0, if8.slice}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {27'd0, obs(8)}, 32'd0);
        end
        run_cmp(8, 16'h0033, 16'h0031, "after_abort");

        // WIDTH=2 exhaustive.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                run_cmp(2, 16'(i), 16'(j), "w2");
            end
        end

        // WIDTH=8 and WIDTH=16 random, biased toward long equal prefixes.
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = ra;
            k  = $urandom_range(0, 4);
            if (k < 4) rb[2*k +: 2] = rb[2*k +: 2] ^ 2'($urandom_range(1, 3));
            run_cmp(8, ra, rb, "w8_rand");
        end
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            if (i % 4 == 0) begin
                rb = 16'($urandom);
            end else begin
                rb = ra;
                k  = $urandom_range(0, 8);
                if (k < 8) rb[2*k +: 2] = rb[2*k +: 2] ^ 2'($urandom_range(1, 3));
            end
            run_cmp(16, ra, rb, "w16_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
